ddr_cmd_arbiter: RTL and testbench
==================================

# ddr_cmd_arbiter

Round-robin command arbiter that shares the single CMD/ADDR/CMDACK request port of the DDR SDRAM controller between NREQ independent requesters. It latches the winning request, holds it on the controller's command port until CMDACK, returns a one-cycle acknowledge to the owner, and then forces the mandatory NOP gap before the next issue. A watchdog aborts any command that the controller does not acknowledge within TIMEOUT cycles. The block sits between the client logic and the controller's command inputs, and runs on the controller's CLK100 domain.

## Interface
- NREQ, 4: number of requesters; 2..8.
- ASIZE, 22: controller address width.
- TIMEOUT, 255: maximum number of ISSUE cycles to wait for CMDACK before aborting; 1..65535.
- IDW, $clog2(NREQ): width of the grant ID.
- CLK  in  1  controller clock (CLK100 domain).
- RESET_N  in  1  reset, asynchronous assert, active-low.
- REQ  in  NREQ  per-requester request level.
- REQ_CMD  in  3*NREQ  per-requester command; slice i = [3i+2:3i].
- REQ_ADDR  in  ASIZE*NREQ  per-requester address; slice i = [ASIZE*i+ASIZE-1:ASIZE*i].
- REQ_ACK  out  NREQ  one-cycle completion pulse to the owning requester.
- GNT_ID  out  IDW  index of the current or last owner.
- BUSY  out  1  high in ISSUE and RELEASE.
- TIMEOUT_ERR  out  1  one-cycle pulse when a command is aborted.
- CMD  out  3  command to the controller; 0 = NOP.
- ADDR  out  ASIZE  address to the controller.
- CMDACK  in  1  acknowledge from the controller.

## Operation
- Reset: async, active-low. State goes to IDLE. CMD=0, ADDR=0, REQ_ACK=0, GNT_ID=0, BUSY=0, TIMEOUT_ERR=0, rr pointer=0, watchdog=0. A reset asserted mid-ISSUE drops CMD to NOP immediately and sends no REQ_ACK.
- Eligibility: requester i is eligible when REQ[i]=1 and REQ_CMD slice i is not 0. A request with REQ high and a NOP command is ignored and never acknowledged.
- IDLE:
  - Pick the first eligible index, searching pointer, pointer+1, … modulo NREQ.
  - On a win: register CMD, ADDR and GNT_ID from the winner's slices; set pointer = winner+1 mod NREQ; clear the watchdog; go to ISSUE.
  - With no eligible requester: stay in IDLE with CMD=0.
- ISSUE:
  - CMD and ADDR hold their latched values. Later changes to REQ, REQ_CMD or REQ_ADDR have no effect.
  - CMDACK=1: on the next edge set CMD=0, pulse REQ_ACK[GNT_ID] high, go to RELEASE.
  - Otherwise, if watchdog = TIMEOUT-1: on the next edge set CMD=0, pulse TIMEOUT_ERR and REQ_ACK[GNT_ID] together, go to RELEASE.
  - Otherwise increment the watchdog (16 bits, saturating).
- RELEASE:
  - Exactly one cycle with CMD=0; REQ_ACK clears.
  - Then go to IDLE. Arbitration resumes on the IDLE cycle.
- Requester rule: hold REQ and the command fields stable until REQ_ACK; deassert REQ on the cycle after REQ_ACK. If REQ is still high in IDLE, the requester is treated as a new request.
- CMDACK arriving in IDLE or RELEASE is ignored.
- CMDACK and watchdog expiry in the same cycle: CMDACK wins and there is no TIMEOUT_ERR.
- GNT_ID keeps the last owner while IDLE.

## Timing
- Request to CMD valid: 1 cycle. REQ is sampled at edge N in IDLE; CMD is valid after edge N.
- CMDACK to REQ_ACK: 1 cycle. CMDACK is sampled at edge M; REQ_ACK is high and CMD=0 after edge M.
- Minimum spacing between two issued commands is 3 cycles: ISSUE (≥1), RELEASE (1), IDLE (1).
- Timeout abort: CMD drops TIMEOUT cycles after entering ISSUE.
- All outputs are registered. There is no combinational path from REQ or CMDACK to any output.

## Structure
- Command encodings go in the shared controller defines include, with named constants: NOP=0, READA=1, WRITEA=2, REFRESH=3, PRECHARGE=4, LOAD_MODE=5, LOAD_REG1=6, LOAD_REG2=7.
- State encoding (IDLE, ISSUE, RELEASE) is local to the block.
- One sub-module, ddr_rr_pick: combinational rotate-priority picker.
  - Inputs: eligible vector, pointer.
  - Outputs: valid, index.
  - Reusable by the data-path scheduler.

## Test plan
- Single requester: REQ[1]=1, REQ_CMD=1 (READA), REQ_ADDR=0x12345; CMDACK after 4 cycles -> CMD=1 and ADDR=0x12345 for 4 cycles, then REQ_ACK=4'b0010 for 1 cycle, CMD=0 for ≥2 cycles.
- All four requesting continuously with immediate CMDACK -> grant order 0,1,2,3,0; each issue spaced exactly 3 cycles.
- Owner changes REQ_ADDR during ISSUE -> ADDR keeps the latched value; REQ_ACK still goes to the original GNT_ID.
- TIMEOUT=8 with CMDACK never asserted -> CMD drops after 8 ISSUE cycles; TIMEOUT_ERR and REQ_ACK pulse together; the next requester is served after RELEASE.
- RESET_N low during ISSUE -> CMD=0 and all outputs at reset values immediately; after release the pointer is 0 and requester 0 wins a tie.
- REQ[2]=1 with REQ_CMD=0 -> never granted; CMD stays 0; BUSY stays 0.

Source files
------------

// File: rtl/ddr_cmd_arbiter_pkg.sv
// Shared controller definitions: command encodings used on the CMD port.
package ddr_cmd_arbiter_pkg;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_READA     = 3'd1;
  localparam logic [2:0] CMD_WRITEA    = 3'd2;
  localparam logic [2:0] CMD_REFRESH   = 3'd3;
  localparam logic [2:0] CMD_PRECHARGE = 3'd4;
  localparam logic [2:0] CMD_LOAD_MODE = 3'd5;
  localparam logic [2:0] CMD_LOAD_REG1 = 3'd6;
  localparam logic [2:0] CMD_LOAD_REG2 = 3'd7;

  // Watchdog counter width; TIMEOUT is limited to what it can count.
  localparam int WDOG_W = 16;

endpackage

// File: rtl/ddr_cmd_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
// slave = arbiter side, master = the surrounding clients and controller.
interface ddr_cmd_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int ASIZE = 22,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     req_cmd;
  logic [ASIZE*NREQ-1:0] req_addr;
  logic [NREQ-1:0]       req_ack;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;
  logic                  timeout_err;
  logic [2:0]            cmd;
  logic [ASIZE-1:0]      addr;
  logic                  cmdack;

  modport master (
    output req, req_cmd, req_addr, cmdack,
    input  req_ack, gnt_id, busy, timeout_err, cmd, addr
  );

  modport slave (
    input  req, req_cmd, req_addr, cmdack,
    output req_ack, gnt_id, busy, timeout_err, cmd, addr
  );
endinterface

// File: rtl/ddr_cmd_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of i_elig found when
// scanning i_ptr, i_ptr+1, ... modulo N.
module ddr_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    logic [IW:0] w_pos;
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (i_elig[w_pos[IW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing the controller command port between NREQ
// requesters. IDLE picks a winner, ISSUE holds the latched command until
// CMDACK or watchdog expiry, RELEASE inserts the mandatory NOP cycle.
module ddr_cmd_arbiter
  import ddr_cmd_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ASIZE   = 22,
  parameter int TIMEOUT = 255,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ddr_cmd_arbiter_if.slave   io_bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RELEASE} state_t;

  state_t              r_state, w_state_next;
  logic [2:0]          r_cmd, w_cmd_next;
  logic [ASIZE-1:0]    r_addr, w_addr_next;
  logic [IDW-1:0]      r_gnt_id, w_gnt_id_next;
  logic [IDW-1:0]      r_ptr, w_ptr_next;
  logic [NREQ-1:0]     r_req_ack, w_req_ack_next;
  logic                r_busy, w_busy_next;
  logic                r_terr, w_terr_next;
  logic [WDOG_W-1:0]   r_wdog, w_wdog_next;

  logic [NREQ-1:0]     w_elig;
  logic [2:0]          w_cmd_arr  [NREQ];
  logic [ASIZE-1:0]    w_addr_arr [NREQ];
  logic                w_pick_valid;
  logic [IDW-1:0]      w_pick_idx;

  // Unpack per-requester slices; a NOP command never counts as a request.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_cmd_arr[gi]  = io_bus.req_cmd[3*gi +: 3];
      assign w_addr_arr[gi] = io_bus.req_addr[ASIZE*gi +: ASIZE];
      assign w_elig[gi]     = io_bus.req[gi] && (w_cmd_arr[gi] != CMD_NOP);
    end
  endgenerate

  ddr_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // State and all outputs are registered; reset drops CMD to NOP at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cmd     <= CMD_NOP;
      r_addr    <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= '0;
      r_req_ack <= '0;
      r_busy    <= 1'b0;
      r_terr    <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cmd     <= w_cmd_next;
      r_addr    <= w_addr_next;
      r_gnt_id  <= w_gnt_id_next;
      r_ptr     <= w_ptr_next;
      r_req_ack <= w_req_ack_next;
      r_busy    <= w_busy_next;
      r_terr    <= w_terr_next;
      r_wdog    <= w_wdog_next;
    end
  end

  // Next-state logic; CMDACK is checked before watchdog expiry so it wins.
  always_comb begin
    w_state_next   = r_state;
    w_cmd_next     = r_cmd;
    w_addr_next    = r_addr;
    w_gnt_id_next  = r_gnt_id;
    w_ptr_next     = r_ptr;
    w_req_ack_next = '0;
    w_terr_next    = 1'b0;
    w_wdog_next    = r_wdog;
    case (r_state)
      ST_IDLE: begin
        w_cmd_next = CMD_NOP;
        if (w_pick_valid) begin
          w_cmd_next    = w_cmd_arr[w_pick_idx];
          w_addr_next   = w_addr_arr[w_pick_idx];
          w_gnt_id_next = w_pick_idx;
          w_ptr_next    = (w_pick_idx == IDW'(NREQ-1)) ? '0 : w_pick_idx + IDW'(1);
          w_wdog_next   = '0;
          w_state_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (io_bus.cmdack) begin
          w_cmd_next               = CMD_NOP;
          w_req_ack_next[r_gnt_id] = 1'b1;
          w_state_next             = ST_RELEASE;
        end else if (r_wdog == WDOG_W'(TIMEOUT-1)) begin
          w_cmd_next               = CMD_NOP;
          w_req_ack_next[r_gnt_id] = 1'b1;
          w_terr_next              = 1'b1;
          w_state_next             = ST_RELEASE;
        end else if (r_wdog != {WDOG_W{1'b1}}) begin
          w_wdog_next = r_wdog + WDOG_W'(1);
        end
      end
      ST_RELEASE: begin
        w_cmd_next   = CMD_NOP;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cmd_next   = CMD_NOP;
        w_state_next = ST_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
  end

  assign io_bus.cmd         = r_cmd;
  assign io_bus.addr        = r_addr;
  assign io_bus.gnt_id      = r_gnt_id;
  assign io_bus.req_ack     = r_req_ack;
  assign io_bus.busy        = r_busy;
  assign io_bus.timeout_err = r_terr;
endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Scoreboard bench for ddr_cmd_arbiter: directed stimulus pushes expected
// issues/acks into queues, a negedge monitor pops and compares them.
module tb_ddr_cmd_arbiter;
  localparam int NREQ    = 4;
  localparam int ASIZE   = 22;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [1:0]       id;
    logic [2:0]       cmd;
    logic [ASIZE-1:0] addr;
    logic [7:0]       gap;   // 0 = spacing not checked
  } issue_t;

  typedef struct packed {
    logic [NREQ-1:0] vec;
    logic            terr;
    logic [7:0]      len;    // cycles CMD was non-NOP
  } ack_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic auto_ack = 1'b0;
  logic manual_ack = 1'b0;
  int   checks = 0;
  int   failures = 0;

  issue_t exp_issue[$];
  ack_t   exp_ack[$];

  always #5 clk = ~clk;

  ddr_cmd_arbiter_if #(.NREQ(NREQ), .ASIZE(ASIZE)) bus ();

  ddr_cmd_arbiter #(.NREQ(NREQ), .ASIZE(ASIZE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  // Controller model: either acks every command immediately or follows the bench.
  assign bus.cmdack = auto_ack ? (bus.cmd != 3'd0) : manual_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic [2:0] c, input logic [ASIZE-1:0] a);
    bus.req[i] = r;
    bus.req_cmd[3*i +: 3] = c;
    bus.req_addr[ASIZE*i +: ASIZE] = a;
  endtask

  task automatic exp_iss(input int id, input int c, input logic [ASIZE-1:0] a, input int gap);
    exp_issue.push_back(issue_t'{2'(id), 3'(c), a, 8'(gap)});
  endtask

  task automatic exp_ak(input logic [NREQ-1:0] v, input logic t, input int len);
    exp_ack.push_back(ack_t'{v, t, 8'(len)});
  endtask

  // Monitor: detects command issue and acknowledge pulses and scores them.
  logic [2:0] prev_cmd = 3'd0;
  int         cyc = 0;
  int         last_issue_cyc = 0;
  int         len = 0;
  issue_t     cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cmd = 3'd0;
      cyc = 0;
      len = 0;
    end else begin
      cyc++;
      if (bus.cmd != 3'd0 && prev_cmd == 3'd0) begin
        check("issue_queued", 32'(exp_issue.size() != 0), 32'd1);
        if (exp_issue.size() != 0) begin
          cur = exp_issue.pop_front();
          $display("issue id=%0d cmd=%0d addr=%h t=%0t", bus.gnt_id, bus.cmd, bus.addr, $time);
          check("issue_gnt_id", 32'(bus.gnt_id), 32'(cur.id));
          check("issue_cmd", 32'(bus.cmd), 32'(cur.cmd));
          check("issue_addr", 32'(bus.addr), 32'(cur.addr));
          check("issue_busy", 32'(bus.busy), 32'd1);
          if (cur.gap != 0) check("issue_gap", 32'(cyc - last_issue_cyc), 32'(cur.gap));
        end
        last_issue_cyc = cyc;
        len = 1;
      end else if (bus.cmd != 3'd0) begin
        len++;
        check("hold_cmd", 32'(bus.cmd), 32'(cur.cmd));
        check("hold_addr", 32'(bus.addr), 32'(cur.addr));
      end
      if (bus.req_ack != '0) begin
        ack_t a;
        check("ack_queued", 32'(exp_ack.size() != 0), 32'd1);
        if (exp_ack.size() != 0) begin
          a = exp_ack.pop_front();
          $display("ack vec=%b terr=%b len=%0d t=%0t", bus.req_ack, bus.timeout_err, len, $time);
          check("ack_vec", 32'(bus.req_ack), 32'(a.vec));
          check("ack_terr", 32'(bus.timeout_err), 32'(a.terr));
          check("ack_issue_len", 32'(len), 32'(a.len));
          check("ack_cmd_nop", 32'(bus.cmd), 32'd0);
        end
      end else if (bus.timeout_err) begin
        check("terr_without_ack", 32'(bus.timeout_err), 32'd0);
      end
      prev_cmd = bus.cmd;
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req = '0;
    bus.req_cmd = '0;
    bus.req_addr = '0;
    rst_n = 1'b0;
    tick(2);
    check("rst_cmd", 32'(bus.cmd), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_req_ack", 32'(bus.req_ack), 32'd0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single requester, CMDACK after 4 ISSUE cycles.
    set_req(1, 1'b1, 3'd1, 22'h12345);
    exp_iss(1, 1, 22'h12345, 0);
    exp_ak(4'b0010, 1'b0, 4);
    tick(1);
    check("t1_busy_issue", 32'(bus.busy), 32'd1);
    tick(3);
    manual_ack = 1'b1;
    tick(1);
    manual_ack = 1'b0;
    set_req(1, 1'b0, 3'd0, '0);
    check("t1_req_ack", 32'(bus.req_ack), 32'b0010);
    check("t1_busy_release", 32'(bus.busy), 32'd1);
    tick(1);
    check("t1_req_ack_clear", 32'(bus.req_ack), 32'd0);
    check("t1_cmd_release", 32'(bus.cmd), 32'd0);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);
    tick(1);
    check("t1_cmd_idle", 32'(bus.cmd), 32'd0);

    // REQ with NOP command is never granted; CMDACK in IDLE is ignored.
    set_req(2, 1'b1, 3'd0, 22'h0BEEF);
    for (int i = 0; i < 6; i++) begin
      manual_ack = (i >= 2 && i < 4);
      tick(1);
      check("nop_req_cmd", 32'(bus.cmd), 32'd0);
      check("nop_req_busy", 32'(bus.busy), 32'd0);
      check("nop_req_ack", 32'(bus.req_ack), 32'd0);
    end
    manual_ack = 1'b0;
    set_req(2, 1'b0, 3'd0, '0);
    tick(1);

    // Owner changes its fields during ISSUE; latched values must hold.
    set_req(2, 1'b1, 3'd2, 22'h0ABCDE);
    exp_iss(2, 2, 22'h0ABCDE, 0);
    exp_ak(4'b0100, 1'b0, 3);
    tick(1);
    set_req(2, 1'b1, 3'd5, 22'h11111);
    tick(2);
    manual_ack = 1'b1;
    tick(1);
    manual_ack = 1'b0;
    set_req(2, 1'b0, 3'd0, '0);
    check("t3_gnt_id_ack", 32'(bus.gnt_id), 32'd2);
    tick(3);
    check("t3_gnt_id_idle", 32'(bus.gnt_id), 32'd2);

    // Timeout: requester 3 is never acked, requester 0 served after RELEASE.
    set_req(3, 1'b1, 3'd6, 22'h2AAAA);
    set_req(0, 1'b1, 3'd1, 22'h00005);
    exp_iss(3, 6, 22'h2AAAA, 0);
    exp_ak(4'b1000, 1'b1, TIMEOUT);
    exp_iss(0, 1, 22'h00005, TIMEOUT + 2);
    exp_ak(4'b0001, 1'b0, 1);
    tick(1);
    tick(TIMEOUT - 1);
    check("t4_cmd_before_expiry", 32'(bus.cmd), 32'd6);
    tick(1);
    set_req(3, 1'b0, 3'd0, '0);
    check("t4_terr", 32'(bus.timeout_err), 32'd1);
    check("t4_cmd_dropped", 32'(bus.cmd), 32'd0);
    tick(2);
    manual_ack = 1'b1;
    set_req(0, 1'b0, 3'd0, '0);
    tick(1);
    manual_ack = 1'b0;
    check("t4_terr_second", 32'(bus.timeout_err), 32'd0);
    tick(2);

    // CMDACK on the very cycle the watchdog expires: ack wins, no error.
    set_req(1, 1'b1, 3'd7, 22'h3FFFFF);
    exp_iss(1, 7, 22'h3FFFFF, 0);
    exp_ak(4'b0010, 1'b0, TIMEOUT);
    tick(1);
    tick(TIMEOUT - 1);
    manual_ack = 1'b1;
    tick(1);
    manual_ack = 1'b0;
    set_req(1, 1'b0, 3'd0, '0);
    check("t4b_terr", 32'(bus.timeout_err), 32'd0);
    tick(3);

    // Reset asserted mid-ISSUE: outputs return to reset values at once.
    set_req(3, 1'b1, 3'd3, 22'h00033);
    exp_iss(3, 3, 22'h00033, 0);
    tick(1);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_cmd", 32'(bus.cmd), 32'd0);
    check("t5_addr", 32'(bus.addr), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("t5_req_ack", 32'(bus.req_ack), 32'd0);
    check("t5_terr", 32'(bus.timeout_err), 32'd0);
    set_req(3, 1'b0, 3'd0, '0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // All four requesting with immediate CMDACK: 0 wins the tie, then 1,2,3,0.
    set_req(0, 1'b1, 3'd2, 22'h00100);
    set_req(1, 1'b1, 3'd3, 22'h00200);
    set_req(2, 1'b1, 3'd4, 22'h00300);
    set_req(3, 1'b1, 3'd5, 22'h2F0F0);
    auto_ack = 1'b1;
    exp_iss(0, 2, 22'h00100, 0);  exp_ak(4'b0001, 1'b0, 1);
    exp_iss(1, 3, 22'h00200, 3);  exp_ak(4'b0010, 1'b0, 1);
    exp_iss(2, 4, 22'h00300, 3);  exp_ak(4'b0100, 1'b0, 1);
    exp_iss(3, 5, 22'h2F0F0, 3);  exp_ak(4'b1000, 1'b0, 1);
    exp_iss(0, 2, 22'h00100, 3);  exp_ak(4'b0001, 1'b0, 1);
    tick(1);
    check("t2_first_gnt", 32'(bus.gnt_id), 32'd0);
    tick(12);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'd0, '0);
    tick(6);
    auto_ack = 1'b0;
    check("t2_idle_busy", 32'(bus.busy), 32'd0);
    tick(2);

    check("issue_queue_drained", 32'(exp_issue.size()), 32'd0);
    check("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
